aes_key_expand: RTL
===================

Name: aes_key_expand

Overview:
- Multi-length AES key-schedule engine; successor to the fixed AES-128 round-key generator.
- Supports AES-128, AES-192 and AES-256 keys (Nk = 4/6/8, Nr = 10/12/14).
- Produces one 32-bit schedule word per cycle and writes each completed 128-bit round key into the round-key RAM.
- Sits between the key-load control path and the round-key storage used by the cipher core.

Parameters:
- ADDR_W, 4, width of rk_addr; must be >= 4 (maximum round-key index is 14).
- RK_BASE, 0, constant added to every rk_addr, so several key slots can share one RAM; RK_BASE+14 must fit in ADDR_W bits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only when busy=0.
- key_len  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=invalid; sampled with start.
- key  input  256  cipher key; byte k of the FIPS-197 key string at key[8k+:8]; only key[32*Nk-1:0] is used; sampled with start.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse coincident with the final rk_we.
- err  output  1  one-cycle pulse when start is accepted with key_len=3.
- rk_we  output  1  round-key write strobe.
- rk_addr  output  ADDR_W  RK_BASE + round index r.
- rk_data  output  128  {w[4r+3], w[4r+2], w[4r+1], w[4r]}.

Behaviour:
- Reset: busy=0, done=0, err=0, rk_we=0, rk_addr=0, rk_data=0; state IDLE. All word and round counters are cleared.
- Reset mid-operation aborts expansion immediately. No rk_we or done is issued after reset, including in the reset cycle itself.
- States: IDLE, GEN, FIN.
- IDLE:
  - start with key_len in 0..2: latch key and Nk; set i=0; go to GEN.
  - start with key_len=3: err=1 next cycle, remain in IDLE, no writes.
- Timing with start sampled at cycle 0 and W = 4*(Nr+1) (44/52/60):
  - busy=1 from cycle 1 through cycle W+1.
  - GEN occupies cycles 1..W and computes w[i] for i=0..W-1, one word per cycle.
- Word generation (byte b of word at bits [8b+:8]; S-box is the team's shared S-box function):
  - i < Nk: w[i] = latched key[32i+:32].
  - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk], with RotWord(b3,b2,b1,b0) = (b0,b3,b2,b1).
  - Nk == 8 and i mod Nk == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - w[i] = w[i-Nk] ^ temp.
- Rcon XORs into byte 0 only; Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- Storage: sliding window of the last 8 words; no full schedule buffer.
- Writes:
  - After the GEN cycle with i mod 4 == 3, the next cycle drives rk_we=1, rk_addr=RK_BASE+i/4, rk_data = last four words.
  - rk_we is high for exactly one cycle per round key; Nr+1 writes total, addresses strictly increasing.
- FIN (cycle W+1): carries the final rk_we; done=1 in that cycle; return to IDLE, busy=0 from cycle W+2.
- start while busy=1 is ignored with no side effects. start in the same cycle busy falls is also ignored; start is accepted from cycle W+2.
- Inputs may change after the start cycle without effect on the current expansion.
- Throughput: one key every W+2 cycles.

Test Plan:
- AES-128, FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c:
  - addr 0 data equals key[127:0].
  - addr 10 FIPS bytes d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 writes; done at cycle 45; busy low at cycle 46.
- AES-192, A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 13 writes.
  - addr 12 FIPS bytes e98ba06f448c773c8ecc720401002202.
  - done at cycle 53.
- AES-256, A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 15 writes.
  - addr 14 FIPS bytes fe4890d1e6188d0b046df344706c631e.
  - done at cycle 61.
- RK_BASE=16, ADDR_W=5, AES-128 run: addresses 16..26 only.
- key_len=3 start: err=1 at cycle 1, busy stays 0, zero rk_we. Second start pulse at cycle 20 of an AES-256 run (same key as the AES-256 scenario, different key on the bus): ignored, output identical to the AES-256 scenario.
- reset asserted at cycle 20 of an AES-128 run:
  - Exactly 4 writes (addr 0..3) observed, none after reset.
  - busy=0, done never pulses.
  - A following start reproduces the full AES-128 vector.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES key-schedule engine for 128/192/256-bit keys.
// Generates one 32-bit schedule word per cycle from a sliding window of the
// last eight words and writes each completed 128-bit round key to the
// round-key RAM at RK_BASE + round index.
module aes_key_expand #(
    parameter int ADDR_W  = 4,
    parameter int RK_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [255:0]      key,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rk_we,
    output logic [ADDR_W-1:0] rk_addr,
    output logic [127:0]      rk_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]   state;
    logic [255:0] key_reg;
    logic [2:0]   nk_m1;     // Nk - 1: 3, 5 or 7
    logic [5:0]   w_last;    // index of the final schedule word (W - 1)
    logic [5:0]   i;         // index of the word produced this cycle
    logic [2:0]   j;         // i mod Nk, tracked incrementally
    logic [7:0]   rcon;      // Rcon[i/Nk] for the next i mod Nk == 0 word
    logic [31:0]  win [8];   // win[k] holds w[i-1-k]

    logic         is_key;
    logic [31:0]  temp;
    logic [31:0]  w_new;

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) general multiply
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // AES S-box: multiplicative inverse (x^254, maps 0 to 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t = x;
        for (int k = 0; k < 6; k++) begin
            t = gf_mul(gf_mul(t, t), x);
        end
        inv = gf_mul(t, t);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // S-box applied to each byte of a word
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign busy = (state != S_IDLE);

    // Next schedule word from the window, the key and the round constant
    always_comb begin
        is_key = (i <= {3'b000, nk_m1});
        temp   = win[0];
        if (j == 3'd0) begin
            temp = sub_word({win[0][7:0], win[0][31:8]}) ^ {24'h000000, rcon};
        end else if (nk_m1 == 3'd7 && j == 3'd4) begin
            temp = sub_word(win[0]);
        end
        if (is_key) begin
            w_new = key_reg[{i[2:0], 5'b00000} +: 32];
        end else begin
            w_new = win[nk_m1] ^ temp;
        end
    end

    // Control FSM, counters and registered round-key write port
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            i       <= 6'd0;
            j       <= 3'd0;
            rcon    <= 8'h01;
            done    <= 1'b0;
            err     <= 1'b0;
            rk_we   <= 1'b0;
            rk_addr <= '0;
            rk_data <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rk_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (key_len == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            key_reg <= key;
                            nk_m1   <= (key_len == 2'd0) ? 3'd3 : (key_len == 2'd1) ? 3'd5 : 3'd7;
                            w_last  <= (key_len == 2'd0) ? 6'd43 : (key_len == 2'd1) ? 6'd51 : 6'd59;
                            i       <= 6'd0;
                            j       <= 3'd0;
                            rcon    <= 8'h01;
                            state   <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    for (int k = 7; k > 0; k--) begin
                        win[k] <= win[k-1];
                    end
                    win[0] <= w_new;
                    i      <= i + 6'd1;
                    j      <= (j == nk_m1) ? 3'd0 : j + 3'd1;
                    if (j == 3'd0 && !is_key) begin
                        rcon <= xtime(rcon);
                    end
                    if (i[1:0] == 2'd3) begin
                        rk_we   <= 1'b1;
                        rk_addr <= ADDR_W'(RK_BASE) + ADDR_W'(i[5:2]);
                        rk_data <= {w_new, win[0], win[1], win[2]};
                    end
                    if (i == w_last) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
